// File: rtl/window5x5_gen.sv
// Streaming 5x5 raster window generator: four line buffers feed a 5x5 shift register.
// Optional macro WINDOW_SOF_EN adds a `sof` input that realigns the counters to pixel (0,0).
module window5x5_gen #(
  parameter int pixelBitWidth = 12,
  parameter int imgWidth      = 640,
  parameter int imgHeight     = 480
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [pixelBitWidth-1:0] pix_in,
  input  logic                     pix_valid,
`ifdef WINDOW_SOF_EN
  input  logic                     sof,
`endif
  output logic [pixelBitWidth-1:0] e1t1, e1t2, e1t3, e1t4, e1t5,
  output logic [pixelBitWidth-1:0] e2t1, e2t2, e2t3, e2t4, e2t5,
  output logic [pixelBitWidth-1:0] e3t1, e3t2, e3t3, e3t4, e3t5,
  output logic [pixelBitWidth-1:0] e4t1, e4t2, e4t3, e4t4, e4t5,
  output logic [pixelBitWidth-1:0] e5t1, e5t2, e5t3, e5t4, e5t5,
  output logic                     win_valid
);

  localparam int COL_W = $clog2(imgWidth);
  localparam int ROW_W = $clog2(imgHeight);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(imgWidth - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(imgHeight - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(4);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(4);

  logic [COL_W-1:0]         col, col_p0;
  logic [ROW_W-1:0]         row, row_p0;
  logic                     acc_p0, sof_p0;
  logic [pixelBitWidth-1:0] lb [4][imgWidth];
  logic [pixelBitWidth-1:0] lb_rd [4];
  logic [pixelBitWidth-1:0] win_p1 [5][5];
  logic                     vld_p1;

  // Stage p0: pixel position of the current accept and line-buffer reads
`ifdef WINDOW_SOF_EN
  assign sof_p0 = sof;
`else
  assign sof_p0 = 1'b0;
`endif
  assign acc_p0 = pix_valid;

  always_comb begin
    col_p0 = sof_p0 ? '0 : col;
    row_p0 = sof_p0 ? '0 : row;
    for (int k = 0; k < 4; k++) lb_rd[k] = lb[k][col_p0];
  end

  // Line buffers cascade one row older per stage; contents are intentionally unreset.
  always_ff @(posedge clk) begin
    if (acc_p0) begin
      lb[0][col_p0] <= pix_in;
      lb[1][col_p0] <= lb_rd[0];
      lb[2][col_p0] <= lb_rd[1];
      lb[3][col_p0] <= lb_rd[2];
    end
  end

  // Stage p1: window register, raster counters and valid strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      vld_p1 <= 1'b0;
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) win_p1[r][c] <= '0;
    end else begin
      vld_p1 <= acc_p0 && !sof_p0 && (row_p0 >= ROW_MIN) && (col_p0 >= COL_MIN);
      if (acc_p0) begin
        if (col_p0 == COL_LAST) begin
          col <= '0;
          row <= (row_p0 == ROW_LAST) ? '0 : row_p0 + ROW_W'(1);
        end else begin
          col <= col_p0 + COL_W'(1);
          row <= row_p0;
        end
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 4; c++) win_p1[r][c] <= win_p1[r][c+1];
        win_p1[4][4] <= pix_in;
        win_p1[3][4] <= lb_rd[0];
        win_p1[2][4] <= lb_rd[1];
        win_p1[1][4] <= lb_rd[2];
        win_p1[0][4] <= lb_rd[3];
      end
    end
  end

  assign win_valid = vld_p1;

  assign e1t1 = win_p1[0][0]; assign e1t2 = win_p1[0][1]; assign e1t3 = win_p1[0][2];
  assign e1t4 = win_p1[0][3]; assign e1t5 = win_p1[0][4];
  assign e2t1 = win_p1[1][0]; assign e2t2 = win_p1[1][1]; assign e2t3 = win_p1[1][2];
  assign e2t4 = win_p1[1][3]; assign e2t5 = win_p1[1][4];
  assign e3t1 = win_p1[2][0]; assign e3t2 = win_p1[2][1]; assign e3t3 = win_p1[2][2];
  assign e3t4 = win_p1[2][3]; assign e3t5 = win_p1[2][4];
  assign e4t1 = win_p1[3][0]; assign e4t2 = win_p1[3][1]; assign e4t3 = win_p1[3][2];
  assign e4t4 = win_p1[3][3]; assign e4t5 = win_p1[3][4];
  assign e5t1 = win_p1[4][0]; assign e5t2 = win_p1[4][1]; assign e5t3 = win_p1[4][2];
  assign e5t4 = win_p1[4][3]; assign e5t5 = win_p1[4][4];

endmodule

// File: tb/tb_window5x5_gen.sv
// Randomized bench for window5x5_gen on an 8x8 image, checked against a frame-array model.
module tb_window5x5_gen;
  localparam int PW = 12;
  localparam int IW = 8;
  localparam int IH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
`ifdef WINDOW_SOF_EN
  logic          sof = 1'b0;
`endif
  wire  [PW-1:0] obs [5][5];
  wire           win_valid;

  always #5 clk = ~clk;

  window5x5_gen #(.pixelBitWidth(PW), .imgWidth(IW), .imgHeight(IH)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
`ifdef WINDOW_SOF_EN
    .sof(sof),
`endif
    .e1t1(obs[0][0]), .e1t2(obs[0][1]), .e1t3(obs[0][2]), .e1t4(obs[0][3]), .e1t5(obs[0][4]),
    .e2t1(obs[1][0]), .e2t2(obs[1][1]), .e2t3(obs[1][2]), .e2t4(obs[1][3]), .e2t5(obs[1][4]),
    .e3t1(obs[2][0]), .e3t2(obs[2][1]), .e3t3(obs[2][2]), .e3t4(obs[2][3]), .e3t5(obs[2][4]),
    .e4t1(obs[3][0]), .e4t2(obs[3][1]), .e4t3(obs[3][2]), .e4t4(obs[3][3]), .e4t5(obs[3][4]),
    .e5t1(obs[4][0]), .e5t2(obs[4][1]), .e5t3(obs[4][2]), .e5t4(obs[4][3]), .e5t5(obs[4][4]),
    .win_valid(win_valid)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: position counters plus the image as written so far this frame
  int            mrow = 0;
  int            mcol = 0;
  logic [PW-1:0] img [IH][IW];
  logic [PW-1:0] exp_win [5][5];
  logic          exp_vld;

  int            pulses, acc_cnt, first_acc;
  logic [PW-1:0] first_e1t1, first_e3t3, first_e5t5, last_e1t1, last_e5t5;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  task automatic push(input logic [PW-1:0] p, input logic v, input logic s);
    int r, c;
    pix_in    = p;
    pix_valid = v;
`ifdef WINDOW_SOF_EN
    sof = s;
`endif
    exp_vld = 1'b0;
    if (v) begin
      if (s) begin r = 0; c = 0; end
      else begin r = mrow; c = mcol; end
      img[r][c] = p;
      exp_vld = (r >= 4) && (c >= 4) && !s;
      if (exp_vld)
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++) exp_win[i][j] = img[r-4+i][c-4+j];
      c++;
      if (c == IW) begin c = 0; r = (r + 1) % IH; end
      mrow = r;
      mcol = c;
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    chk("win_valid", win_valid, exp_vld);
    if (win_valid === 1'b1) begin
      pulses++;
      if (pulses == 1) begin
        first_acc  = acc_cnt;
        first_e1t1 = obs[0][0];
        first_e3t3 = obs[2][2];
        first_e5t5 = obs[4][4];
      end
      last_e1t1 = obs[0][0];
      last_e5t5 = obs[4][4];
    end
    if (exp_vld)
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          chk($sformatf("win e%0dt%0d @%0d,%0d", i+1, j+1, mrow, mcol), obs[i][j], exp_win[i][j]);
    pix_valid = 1'b0;
`ifdef WINDOW_SOF_EN
    sof = 1'b0;
`endif
  endtask

  task automatic stream(input int npix, input int gap_pct, input bit rnd, input bit use_sof,
                        input string name);
    logic [PW-1:0] val;
    logic          idle_sof;
    pulses = 0; acc_cnt = 0; first_acc = 0;
    for (int k = 0; k < npix; k++) begin
      while ($urandom_range(99) < gap_pct) begin
`ifdef WINDOW_SOF_EN
        idle_sof = 1'($urandom_range(1));
`else
        idle_sof = 1'b0;
`endif
        push(PW'($urandom), 1'b0, idle_sof);
      end
      val = rnd ? PW'($urandom) : PW'(16 * (k / IW) + (k % IW));
      push(val, 1'b1, use_sof && (k == 0));
    end
    if (npix == IW * IH) chk({name, " pulses"}, pulses, 16);
  endtask

  // Asynchronous reset mid-cycle, away from any clock edge
  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst win_valid", win_valid, 1'b0);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) chk($sformatf("rst e%0dt%0d", i+1, j+1), obs[i][j], '0);
    rst  = 1'b0;
    mrow = 0;
    mcol = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    stream(10, 0, 1'b0, 1'b0, "pre");
    do_reset();

    stream(IW * IH, 0, 1'b0, 1'b0, "cont");
    chk("cont first acc", first_acc, 37);
    chk("cont first e1t1", first_e1t1, 12'h000);
    chk("cont first e3t3", first_e3t3, 12'h022);
    chk("cont first e5t5", first_e5t5, 12'h044);
    chk("cont last e5t5", last_e5t5, 12'h077);
    chk("cont last e1t1", last_e1t1, 12'h033);

    stream(IW * IH, 50, 1'b0, 1'b0, "gaps");
    chk("gaps first e5t5", first_e5t5, 12'h044);

    stream(IW * IH, 0, 1'b1, 1'b0, "frameA");
    stream(IW * IH, 30, 1'b1, 1'b0, "frameB");

    stream(5 * IW + 4, 0, 1'b0, 1'b0, "partial");
    do_reset();
    stream(IW * IH, 0, 1'b0, 1'b0, "after rst");
    chk("after rst first acc", first_acc, 37);
    chk("after rst first e5t5", first_e5t5, 12'h044);

`ifdef WINDOW_SOF_EN
    stream(20, 0, 1'b1, 1'b0, "pre sof");
    stream(IW * IH, 20, 1'b0, 1'b1, "sof");
    chk("sof first acc", first_acc, 37);
    chk("sof first e5t5", first_e5t5, 12'h044);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
